// File: rtl/pll_reset_sequencer.sv
// Purpose: owns the ECP5 PLL RST pulse, qualifies async LOCK, and gates the active-low core reset.
// Latency: LOCK rise to sys_rst_n release = 2 sync + 1 + STABLE_CYCLES clocks; LOCK loss to core reset = 3 clocks.
// Backpressure: none; restart preempts every transition. Define PLL_SEQ_RETRY_LIMIT_EN to enable the FAIL state.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 17
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [2:0] state,
  output logic [3:0] retries,
  output logic [7:0] lock_losses,
  output logic       fail
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    , FAIL    = 3'd4
`endif
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  // Where a timeout with an exhausted budget lands; without the limit it simply retries.
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam state_t GIVE_UP_STATE = FAIL;
`else
  localparam state_t GIVE_UP_STATE = RESET_PLL;
`endif

  state_t           cur_state;
  state_t           nxt_state;
  logic             sync_q;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       retries_nxt;
  logic [3:0]       retries_sat;
  logic [7:0]       losses_nxt;
  logic [7:0]       losses_sat;
  logic             pll_rst_d;

  assign state       = cur_state;
  assign retries_sat = (retries == 4'hF) ? retries : retries + 4'd1;
  assign losses_sat  = (lock_losses == 8'hFF) ? lock_losses : lock_losses + 8'd1;

  // Two-flop synchronizer for the PLL LOCK output; the FSM only ever sees lock_s.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= pll_lock;
      lock_s <= sync_q;
    end
  end

  // Next-state, counter bookkeeping and output decode; restart overrides everything.
  always_comb begin
    nxt_state   = cur_state;
    retries_nxt = retries;
    losses_nxt  = lock_losses;
    if (restart) begin
      nxt_state   = RESET_PLL;
      retries_nxt = 4'd0;
    end else begin
      case (cur_state)
        RESET_PLL: if (cnt == RST_LAST) nxt_state = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            nxt_state = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            retries_nxt = retries_sat;
            nxt_state   = (retries == RETRY_LIMIT) ? GIVE_UP_STATE : RESET_PLL;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            nxt_state = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            nxt_state   = RUN;
            retries_nxt = 4'd0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            nxt_state  = WAIT_LOCK;
            losses_nxt = losses_sat;
          end
        end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        FAIL: nxt_state = FAIL;
`endif
        default: nxt_state = RESET_PLL;
      endcase
    end
    pll_rst_d = (nxt_state == RESET_PLL);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    if (nxt_state == FAIL) pll_rst_d = 1'b1;
`endif
  end

  // State, shared counter (cleared on any state change or restart) and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state   <= RESET_PLL;
      cnt         <= '0;
      retries     <= 4'd0;
      lock_losses <= 8'd0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      retries     <= retries_nxt;
      lock_losses <= losses_nxt;
      pll_rst     <= pll_rst_d;
      sys_rst_n   <= (nxt_state == RUN);
      if (restart || (nxt_state != cur_state)) cnt <= '0;
      else if (cnt != '1)                      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  // Budget-exhausted flag, registered alongside the state it decodes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fail <= 1'b0;
    else          fail <= (nxt_state == FAIL);
  end
`else
  assign fail = 1'b0;
`endif

endmodule
